// File: rtl/irq_pending_if.sv
// irq_pending_if: request lines, pencoder d/y/v link and consumer handshake for irq_pending
interface irq_pending_if;
  logic [3:0] irq;
  logic [3:0] mask;
  logic [3:0] d;
  logic [3:0] pending;
  logic [1:0] y;
  logic       v;
  logic       ack;
  logic       int_req;
  logic [1:0] int_id;
  modport master (
    output irq, mask, y, v, ack,
    input  d, pending, int_req, int_id
  );
  modport slave (
    input  irq, mask, y, v, ack,
    output d, pending, int_req, int_id
  );
endinterface

// File: rtl/irq_pending.sv
// irq_pending: synchronises and edge-latches request lines, feeds pencoder, and runs
// the int_req/ack handshake that clears the serviced pending bit.
module irq_pending #(
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  irq_pending_if.slave p
);
  typedef enum logic {IDLE, REQ} state_t;
  localparam int CW = SYNC_STAGES * 4;
  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);
  logic [CW-1:0] chain;
  logic [3:0]    dly, sync, rise, clr, pending_q;
  logic [2:0]    warm;
  logic          req_q, req_n;
  logic [1:0]    id_q, id_n;
  state_t        state, state_n;
  assign sync = chain[CW-1 -: 4];
  // Edges are suppressed until the chain holds post-reset samples, so a line
  // already high at reset release is not mistaken for a new request.
  assign rise = (warm == WARM) ? sync & ~dly : '0;
  assign p.d = pending_q & ~p.mask;
  assign p.pending = pending_q;
  assign p.int_req = req_q;
  assign p.int_id = id_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain     <= '0;
      dly       <= '0;
      warm      <= '0;
      pending_q <= '0;
      req_q     <= 1'b0;
      id_q      <= '0;
      state     <= IDLE;
    end else begin
      chain     <= {chain[CW-5:0], p.irq};
      dly       <= sync;
      warm      <= (warm == WARM) ? warm : warm + 3'd1;
      pending_q <= (pending_q & ~clr) | rise;
      req_q     <= req_n;
      id_q      <= id_n;
      state     <= state_n;
    end
  end
  always_comb begin
    state_n = state;
    req_n   = req_q;
    id_n    = id_q;
    clr     = '0;
    if (state == IDLE && p.v) begin
      state_n = REQ;
      req_n   = 1'b1;
      id_n    = p.y;
    end else if (state == REQ && p.ack) begin
      state_n = IDLE;
      req_n   = 1'b0;
      clr     = 4'b0001 << id_q;
    end
  end
endmodule

// File: tb/tb_irq_pending.sv
// tb_irq_pending: directed test of irq_pending with a behavioural priority encoder in the loop.
module tb_irq_pending;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  irq_pending_if bus ();
  irq_pending #(.SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .p(bus.slave));
  always #5 clk = ~clk;
  always_comb begin
    bus.v = |bus.d;
    bus.y = bus.d[3] ? 2'd3 : bus.d[2] ? 2'd2 : bus.d[1] ? 2'd1 : 2'd0;
  end
  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.irq = 4'b0101;
    bus.mask = 4'b0000;
    bus.ack = 1'b0;
    edge_n(3);
    chk("rst_pending", 8'(bus.pending), 8'h0);
    chk("rst_int_req", 8'(bus.int_req), 8'h0);
    chk("rst_int_id", 8'(bus.int_id), 8'h0);
    reset = 1'b0;
    edge_n(8);
    chk("t1_pending", 8'(bus.pending), 8'h0);
    chk("t1_int_req", 8'(bus.int_req), 8'h0);
    bus.irq = 4'b0000;
    edge_n(3);
    bus.irq = 4'b0010;
    edge_n(1);
    bus.irq = 4'b0000;
    edge_n(1);
    chk("t2_pending_k1", 8'(bus.pending), 8'h0);
    edge_n(1);
    chk("t2_pending_k2", 8'(bus.pending), 8'h2);
    chk("t2_req_k2", 8'(bus.int_req), 8'h0);
    edge_n(1);
    chk("t2_req_k3", 8'(bus.int_req), 8'h1);
    chk("t2_id_k3", 8'(bus.int_id), 8'h1);
    bus.ack = 1'b1;
    edge_n(1);
    bus.ack = 1'b0;
    chk("t2_pending_ack", 8'(bus.pending), 8'h0);
    chk("t2_req_ack", 8'(bus.int_req), 8'h0);
    bus.irq = 4'b1010;
    edge_n(1);
    bus.irq = 4'b0000;
    edge_n(2);
    chk("t3_pending", 8'(bus.pending), 8'ha);
    edge_n(1);
    chk("t3_req1", 8'(bus.int_req), 8'h1);
    chk("t3_id1", 8'(bus.int_id), 8'h3);
    bus.ack = 1'b1;
    edge_n(1);
    bus.ack = 1'b0;
    chk("t3_req_gap", 8'(bus.int_req), 8'h0);
    chk("t3_pending_mid", 8'(bus.pending), 8'h2);
    edge_n(1);
    chk("t3_req2", 8'(bus.int_req), 8'h1);
    chk("t3_id2", 8'(bus.int_id), 8'h1);
    bus.ack = 1'b1;
    edge_n(1);
    bus.ack = 1'b0;
    chk("t3_pending_end", 8'(bus.pending), 8'h0);
    chk("t3_req_end", 8'(bus.int_req), 8'h0);
    bus.mask = 4'b1000;
    bus.irq = 4'b1000;
    edge_n(1);
    bus.irq = 4'b0000;
    edge_n(2);
    chk("t4_pending", 8'(bus.pending), 8'h8);
    chk("t4_d_masked", 8'(bus.d), 8'h0);
    edge_n(2);
    chk("t4_no_req", 8'(bus.int_req), 8'h0);
    bus.mask = 4'b0000;
    #1;
    chk("t4_d_unmasked", 8'(bus.d), 8'h8);
    edge_n(1);
    chk("t4_req", 8'(bus.int_req), 8'h1);
    chk("t4_id", 8'(bus.int_id), 8'h3);
    bus.ack = 1'b1;
    edge_n(1);
    bus.ack = 1'b0;
    chk("t4_pending_ack", 8'(bus.pending), 8'h0);
    bus.irq = 4'b0100;
    edge_n(1);
    bus.irq = 4'b0000;
    edge_n(3);
    chk("t5_req", 8'(bus.int_req), 8'h1);
    chk("t5_id", 8'(bus.int_id), 8'h2);
    bus.irq = 4'b0100;
    edge_n(1);
    bus.irq = 4'b0000;
    edge_n(1);
    bus.ack = 1'b1;
    edge_n(1);
    bus.ack = 1'b0;
    chk("t5_pending_kept", 8'(bus.pending), 8'h4);
    chk("t5_req_drop", 8'(bus.int_req), 8'h0);
    edge_n(1);
    chk("t5_req_again", 8'(bus.int_req), 8'h1);
    chk("t5_id_again", 8'(bus.int_id), 8'h2);
    bus.mask = 4'b0100;
    edge_n(2);
    chk("t5_mask_hold_req", 8'(bus.int_req), 8'h1);
    chk("t5_mask_hold_id", 8'(bus.int_id), 8'h2);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_req", 8'(bus.int_req), 8'h0);
    chk("t6_async_pending", 8'(bus.pending), 8'h0);
    reset = 1'b0;
    bus.mask = 4'b1111;
    edge_n(6);
    bus.irq = 4'b0001;
    edge_n(1);
    bus.irq = 4'b0000;
    edge_n(2);
    chk("t6_masked_pending", 8'(bus.pending), 8'h1);
    bus.ack = 1'b1;
    edge_n(2);
    bus.ack = 1'b0;
    chk("t6_idle_ack_pending", 8'(bus.pending), 8'h1);
    chk("t6_idle_ack_req", 8'(bus.int_req), 8'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
